// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one upstream master per burst and steers the bridge response back to it.
// Build option CBUS_ARB_RR_EN selects round-robin arbitration; fixed priority (index 0 highest) otherwise.
package cbus_arbiter_pkg;
    localparam logic [1:0] MLEN1 = 2'd0;
    localparam logic [1:0] MLEN2 = 2'd1;
    localparam logic [1:0] MLEN4 = 2'd2;
    localparam logic [1:0] MLEN8 = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  cbus_req_t          ireqs  [NUM_REQ],
    output cbus_resp_t         oresps [NUM_REQ],
    output cbus_req_t          oreq,
    input  cbus_resp_t         iresp,
    output logic               busy,
    output logic [ID_BITS-1:0] grant_id
);
    localparam int PAD = 1 << ID_BITS;

    typedef enum logic { IDLE, GRANT } state_t;

    state_t               state, state_n;
    logic [ID_BITS-1:0]   grant_n;
    logic [ID_BITS-1:0]   winner;
    logic                 any_req;
    logic [PAD-1:0]       vld_pad;
`ifdef CBUS_ARB_RR_EN
    logic [ID_BITS-1:0]   rr_ptr, rr_n;
    int                   sum;
    logic [ID_BITS-1:0]   idx;
`endif

    always_comb begin
        vld_pad = '0;
        for (int i = 0; i < NUM_REQ; i++) vld_pad[i] = ireqs[i].valid;
    end

    // Scan from lowest priority to highest so the highest-priority hit is written last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
`ifdef CBUS_ARB_RR_EN
        sum = 0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = ID_BITS'(sum);
            if (vld_pad[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vld_pad[k]) begin
                any_req = 1'b1;
                winner  = ID_BITS'(k);
            end
        end
`endif
    end

    always_comb begin
        state_n = state;
        grant_n = grant_id;
`ifdef CBUS_ARB_RR_EN
        rr_n    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = GRANT;
                    grant_n = winner;
`ifdef CBUS_ARB_RR_EN
                    rr_n = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
`endif
                end
            end
            GRANT: begin
                if (iresp.ready && iresp.last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
`ifdef CBUS_ARB_RR_EN
            rr_ptr   <= '0;
`endif
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
`ifdef CBUS_ARB_RR_EN
            rr_ptr   <= rr_n;
`endif
        end
    end

    assign busy = (state == GRANT);

    // Outputs depend only on registered state in IDLE, so ireqs never reaches oreq.valid there.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oresps[i] = '0;
            if (busy && grant_id == ID_BITS'(i)) begin
                oreq      = ireqs[i];
                oresps[i] = iresp;
            end
        end
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized and directed bench for cbus_arbiter against a transaction-level ownership model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int IB = 2;

    logic            clk = 1'b0;
    logic            reset;
    cbus_req_t       ireqs  [N];
    cbus_resp_t      oresps [N];
    cbus_req_t       oreq;
    cbus_resp_t      iresp;
    logic            busy;
    logic [IB-1:0]   grant_id;

    cbus_arbiter #(.NUM_REQ(N), .ID_BITS(IB)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .oresps(oresps),
        .oreq(oreq), .iresp(iresp), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Model: who owns the bus (if anyone), and where the round-robin search starts.
    bit m_busy;
    int m_gid;
    int m_rr;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick();
        int start;
`ifdef CBUS_ARB_RR_EN
        start = m_rr;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++)
            if (ireqs[(start + k) % N].valid) return (start + k) % N;
        return -1;
    endfunction

    function automatic cbus_req_t mkreq(input logic [31:0] a, input logic [1:0] l, input logic w);
        cbus_req_t r;
        r.valid = 1'b1; r.is_write = w; r.addr = a; r.len = l;
        r.wdata = $urandom; r.wstrb = 4'hf;
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy; r.last = lst; r.data = d;
        return r;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        iresp = '0;
    endtask

    // Caller sets inputs just after an edge; check outputs, advance model, cross next edge.
    task automatic step();
        cbus_req_t  eq;
        cbus_resp_t er;
        int         w;
        #1;
        check("busy", 128'(busy), 128'(m_busy));
        check("grant_id", 128'(grant_id), 128'(m_gid));
        eq = m_busy ? ireqs[m_gid] : '0;
        check("oreq", 128'(oreq), 128'(eq));
        for (int i = 0; i < N; i++) begin
            er = (m_busy && m_gid == i) ? iresp : '0;
            check($sformatf("oresps%0d", i), 128'(oresps[i]), 128'(er));
        end
        if (reset) begin
            m_busy = 0; m_gid = 0; m_rr = 0;
        end else if (!m_busy) begin
            w = pick();
            if (w >= 0) begin
                m_busy = 1; m_gid = w; m_rr = (w + 1) % N;
            end
        end else if (iresp.ready && iresp.last) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
    endtask

    int         gq[$];
    bit         prevb;
    int         exp_seq[4];

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        m_busy = 0; m_gid = 0; m_rr = 0;

        // Reset held two cycles with a request pending, then first grant one cycle later.
        ireqs[0] = mkreq(32'h1000_0040, MLEN1, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("first_grant_addr", 128'(oreq.addr), 128'(32'h1000_0040));
        iresp = mkresp(1'b1, 1'b1, 32'hdead_0001);
        ireqs[0].valid = 1'b0;
        step();
        clear_inputs();
        step();

        // Single 4-beat read burst from requester 1.
        ireqs[1] = mkreq(32'h8000_0010, MLEN4, 1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            iresp = mkresp(1'b1, b == 3, 32'(8'h11 * (b + 1)));
            if (b == 0) ireqs[1].valid = 1'b0;
            step();
        end
        iresp = '0;
        step();
        check("burst_done_busy", 128'(busy), 128'(0));

        // Continuous contention between 0 and 1 with single-beat bursts.
        do_reset();
        ireqs[0] = mkreq(32'h0000_0100, MLEN1, 1'b0);
        ireqs[1] = mkreq(32'h0000_0200, MLEN1, 1'b1);
        gq.delete();
        prevb = 0;
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            iresp = m_busy ? mkresp(1'b1, 1'b1, $urandom) : '0;
            step();
            if (busy && !prevb) gq.push_back(int'(grant_id));
            prevb = busy;
        end
`ifdef CBUS_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        check("contention_count", 128'(gq.size()), 128'(4));
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("contention_seq%0d", i), 128'(gq[i]), 128'(exp_seq[i]));
        clear_inputs();
        step();
        step();

        // Requester 0 drops valid mid-burst; grant is held until last.
        do_reset();
        ireqs[0] = mkreq(32'h0000_0300, MLEN4, 1'b0);
        ireqs[1] = mkreq(32'h0000_0400, MLEN1, 1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            iresp = mkresp(1'b1, b == 3, $urandom);
            if (b == 2) ireqs[0].valid = 1'b0;
            step();
            check("drop_hold_gid", 128'(grant_id), 128'(0));
        end
        iresp = '0;
        step();
        check("drop_next_gid", 128'(grant_id), 128'(1));
        check("drop_next_busy", 128'(busy), 128'(1));
        iresp = mkresp(1'b1, 1'b1, 32'h5);
        step();
        clear_inputs();
        step();

        // Reset at beat 2 of a write burst, then a fresh request from requester 0.
        do_reset();
        ireqs[1] = mkreq(32'h0000_0500, MLEN4, 1'b1);
        step();
        iresp = mkresp(1'b1, 1'b0, 32'h1);
        step();
        iresp = mkresp(1'b1, 1'b0, 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        step();
        ireqs[0] = mkreq(32'h0000_0600, MLEN2, 1'b0);
        step();
        check("post_reset_busy", 128'(busy), 128'(1));
        check("post_reset_gid", 128'(grant_id), 128'(0));
        iresp = mkresp(1'b1, 1'b1, 32'h7);
        step();
        clear_inputs();
        step();

        // Random traffic, including bridge activity while idle and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                ireqs[i] = mkreq($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                ireqs[i].valid = ($urandom_range(0, 2) == 0);
            end
            iresp = mkresp(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
